// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of the single BRAM/GPIO access port.
// One transaction at a time: IDLE -> ACCESS -> WAIT (RD_LATENCY cycles) -> RESP.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic              m0_unsigned,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic              m1_unsigned,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,

    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_data_in,
    output logic              s_load_enable,
    output logic              s_store_enable,
    output logic              s_is_lb,
    output logic              s_is_lbu,
    output logic              s_is_lh,
    output logic              s_is_lhu,
    output logic              s_is_lw,
    output logic              s_is_sb,
    output logic              s_is_sh,
    output logic              s_is_sw,
    input  logic [DATA_W-1:0] s_data_out,

    output logic              busy,
    output logic              grant
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        WAIT_LAT = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY - 1);

    state_t            state_reg, state_next;
    logic              gnt_reg;
    logic              last_grant_reg;
    logic              we_reg;
    logic [1:0]        size_reg;
    logic              uns_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [3:0]        cnt_reg;

    logic              take_grant;
    logic              grant_sel;
    logic [1:0]        req_vec;
    logic [1:0]        ack_vec;
    logic [DATA_W-1:0] rdata_bus [2];
    logic [7:0]        flags;

    assign req_vec = {m1_req, m0_req};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // On a tie the master that did not win last time is chosen.
    always_comb begin
        state_next = state_reg;
        take_grant = 1'b0;
        grant_sel  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_vec != 2'b00) begin
                    take_grant = 1'b1;
                    grant_sel  = (&req_vec) ? ~last_grant_reg : req_vec[1];
                    state_next = ACCESS;
                end
            end
            ACCESS:   state_next = WAIT_LAT;
            WAIT_LAT: if (cnt_reg == 4'd0) state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_reg        <= 1'b0;
            last_grant_reg <= 1'b1;
            we_reg         <= 1'b0;
            size_reg       <= 2'b00;
            uns_reg        <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cnt_reg        <= 4'd0;
        end else begin
            if (take_grant) begin
                gnt_reg   <= grant_sel;
                we_reg    <= grant_sel ? m1_we       : m0_we;
                size_reg  <= grant_sel ? m1_size     : m0_size;
                uns_reg   <= grant_sel ? m1_unsigned : m0_unsigned;
                addr_reg  <= grant_sel ? m1_addr     : m0_addr;
                wdata_reg <= grant_sel ? m1_wdata    : m0_wdata;
            end
            if (state_reg == ACCESS) begin
                cnt_reg <= CNT_INIT;
            end else if (state_reg == WAIT_LAT && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (state_reg == RESP) begin
                last_grant_reg <= gnt_reg;
            end
        end
    end

    // Access-type decode; only meaningful during the single ACCESS cycle.
    always_comb begin
        flags = 8'h00;
        if (state_reg == ACCESS) begin
            if (we_reg) begin
                case (size_reg)
                    2'b00:   flags[2] = 1'b1;
                    2'b01:   flags[1] = 1'b1;
                    default: flags[0] = 1'b1;
                endcase
            end else begin
                case (size_reg)
                    2'b00:   flags[uns_reg ? 6 : 7] = 1'b1;
                    2'b01:   flags[uns_reg ? 4 : 5] = 1'b1;
                    default: flags[3] = 1'b1;
                endcase
            end
        end
    end

    assign {s_is_lb, s_is_lbu, s_is_lh, s_is_lhu, s_is_lw, s_is_sb, s_is_sh, s_is_sw} = flags;

    assign s_load_enable  = (state_reg == ACCESS) && !we_reg;
    assign s_store_enable = (state_reg == ACCESS) &&  we_reg;
    assign s_address      = addr_reg;
    assign s_data_in      = wdata_reg;
    assign busy           = (state_reg != IDLE);
    assign grant          = gnt_reg;

    // Per-master response path; rdata persists until that master's next completion.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic [DATA_W-1:0] rdata_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if (state_reg == WAIT_LAT && cnt_reg == 4'd0 && gnt_reg == 1'(gi)) begin
                    rdata_reg <= we_reg ? '0 : s_data_out;
                end
            end

            assign rdata_bus[gi] = rdata_reg;
            assign ack_vec[gi]   = (state_reg == RESP) && (gnt_reg == 1'(gi));
        end
    endgenerate

    assign m0_rdata = rdata_bus[0];
    assign m1_rdata = rdata_bus[1];
    assign m0_ack   = ack_vec[0];
    assign m1_ack   = ack_vec[1];

endmodule
